// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch controller sitting right after the PC register. It
//   takes the current PC, runs a req/ack transaction to instruction memory
//   and loads the IF/ID pipeline register with {valid, PC+4, instruction}.
//   pc_enable_o tells the PC register when to advance (instruction accepted)
//   or load a branch/jump target (flush).
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-low reset
//   start_i            CPU run enable (0 = idle)
//   pc_i               current PC
//   hd_i               hazard stall from ID, IF/ID must hold
//   flush_i            branch/jump taken, squash IF contents
//   imem_req_o         memory request, held until imem_ack_i
//   imem_addr_o        registered request address
//   imem_ack_i         one-cycle completion strobe
//   imem_data_i        instruction word, valid with ack
//   pc_enable_o        combinational PC load enable
//   ifid_valid_o       IF/ID holds a real instruction
//   ifid_pc4_o         PC+4 of the IF/ID instruction
//   ifid_instr_o       IF/ID instruction word
//   stall_cnt_o        stall cycle count (macro IF_STALL_CNT_EN, else 0)
//
// Optional feature macro: IF_STALL_CNT_EN
//
// State    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | no request; waits for start_i, also the one-cycle redirect gap
// S_FETCH  | request outstanding at imem_addr_o
// S_HOLD   | instruction buffered while ID stalls; no request
// S_DRAIN  | request still owed an ack, data will be thrown away
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      pc_i,
    input  logic             hd_i,
    input  logic             flush_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    output logic             pc_enable_o,
    output logic             ifid_valid_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        pc_enable;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        buf_valid_d  = buf_valid_q;
        buf_pc4_d    = buf_pc4_q;
        buf_instr_d  = buf_instr_q;
        pc_enable    = 1'b0;

        // A flush squashes whatever IF holds, in every state.
        if (flush_i) begin
            pc_enable    = 1'b1;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            buf_valid_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // After a flush the target is only on pc_i next cycle,
                // so stay here one cycle and sample it then.
                if (!flush_i && start_i) begin
                    addr_d  = pc_i;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (flush_i || !start_i) begin
                    ifid_valid_d = 1'b0;
                    // Outstanding request must still be acked before
                    // a new one may be issued.
                    state_d = imem_ack_i ? S_IDLE : S_DRAIN;
                end else if (imem_ack_i && !hd_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc4_d   = addr_q + 32'd4;
                    ifid_instr_d = imem_data_i;
                    pc_enable    = 1'b1;
                    addr_d       = pc_i + 32'd4;
                end else if (imem_ack_i) begin
                    buf_valid_d = 1'b1;
                    buf_pc4_d   = addr_q + 32'd4;
                    buf_instr_d = imem_data_i;
                    state_d     = S_HOLD;
                end else if (!hd_i) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (!start_i) begin
                    ifid_valid_d = 1'b0;
                    buf_valid_d  = 1'b0;
                    state_d      = S_IDLE;
                end else if (!hd_i) begin
                    ifid_valid_d = buf_valid_q;
                    ifid_pc4_d   = buf_pc4_q;
                    ifid_instr_d = buf_instr_q;
                    buf_valid_d  = 1'b0;
                    pc_enable    = 1'b1;
                    addr_d       = pc_i + 32'd4;
                    state_d      = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_ack_i) begin
                    // A flush landing on the ack moves the PC again, so
                    // take the redirect gap through IDLE instead.
                    if (start_i && !flush_i) begin
                        addr_d  = pc_i;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            addr_q       <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            buf_valid_q  <= 1'b0;
            buf_pc4_q    <= 32'd0;
            buf_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            buf_valid_q  <= buf_valid_d;
            buf_pc4_q    <= buf_pc4_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign pc_enable_o  = pc_enable;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;

`ifdef IF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_cycle;

    always_comb begin
        stall_cycle = ((state_q == S_FETCH) && !imem_ack_i) ||
                      (state_q == S_HOLD) || (state_q == S_DRAIN);
        stall_cnt_d = stall_cnt_q;
        if (stall_cycle && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Directed bench for if_fetch_ctrl. Each task drives one scenario and
//   compares outputs against hand-computed values. Inputs change 1 time unit
//   after the rising edge; outputs are sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        hd_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic        pc_enable_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic [15:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    if_fetch_ctrl #(.NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .pc_i        (pc_i),
        .hd_i        (hd_i),
        .flush_i     (flush_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .pc_enable_o (pc_enable_o),
        .ifid_valid_o(ifid_valid_o),
        .ifid_pc4_o  (ifid_pc4_o),
        .ifid_instr_o(ifid_instr_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
        total++; if (imem_addr_o !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr_o); end
        total++; if (ifid_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ifid_valid_o); end
        total++; if (ifid_pc4_o !== 32'd0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", ifid_pc4_o); end
        total++; if (ifid_instr_o !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr_o, NOP); end
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt_o); end
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL rst_pcen got=%b exp=0", pc_enable_o); end
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_basic();
        pc_i = 32'd0; start_i = 1'b1; #1;
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL idle_pcen got=%b exp=0", pc_enable_o); end
        tick();
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", imem_req_o); end
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL basic_addr got=%h exp=0", imem_addr_o); end
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL basic_pcen_wait got=%b exp=0", pc_enable_o); end
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h2001_0005; #1;
        total++; if (pc_enable_o !== 1'b1) begin bad++; $display("FAIL basic_pcen_ack got=%b exp=1", pc_enable_o); end
        tick();
        imem_ack_i = 1'b0; pc_i = 32'h4; #1;
        total++; if (ifid_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", ifid_valid_o); end
        total++; if (ifid_pc4_o !== 32'h4) begin bad++; $display("FAIL basic_pc4 got=%h exp=4", ifid_pc4_o); end
        total++; if (ifid_instr_o !== 32'h2001_0005) begin bad++; $display("FAIL basic_instr got=%h exp=20010005", ifid_instr_o); end
        total++; if (imem_addr_o !== 32'h4) begin bad++; $display("FAIL basic_next_addr got=%h exp=4", imem_addr_o); end
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL basic_pcen_once got=%b exp=0", pc_enable_o); end
        tick();
        total++; if (ifid_valid_o !== 1'b0) begin bad++; $display("FAIL basic_bubble got=%b exp=0", ifid_valid_o); end
        total++; if (ifid_instr_o !== NOP) begin bad++; $display("FAIL basic_bubble_instr got=%h exp=%h", ifid_instr_o, NOP); end
        imem_ack_i = 1'b1; imem_data_i = 32'h1111_2222; #1;
        total++; if (pc_enable_o !== 1'b1) begin bad++; $display("FAIL basic_pcen_ack2 got=%b exp=1", pc_enable_o); end
        tick();
        imem_ack_i = 1'b0; pc_i = 32'h8;
        total++; if (ifid_pc4_o !== 32'h8) begin bad++; $display("FAIL basic_pc4_2 got=%h exp=8", ifid_pc4_o); end
        total++; if (ifid_instr_o !== 32'h1111_2222) begin bad++; $display("FAIL basic_instr2 got=%h exp=11112222", ifid_instr_o); end
        total++; if (imem_addr_o !== 32'h8) begin bad++; $display("FAIL basic_addr2 got=%h exp=8", imem_addr_o); end
    endtask

    task automatic test_delayed_ack();
        logic [15:0] s0;
        s0 = stall_cnt_o;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin bad++; $display("FAIL dly_req_hold[%0d] got=%b/%h exp=1/8", i, imem_req_o, imem_addr_o); end
            total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL dly_pcen[%0d] got=%b exp=0", i, pc_enable_o); end
            tick();
            total++; if (ifid_valid_o !== 1'b0) begin bad++; $display("FAIL dly_valid[%0d] got=%b exp=0", i, ifid_valid_o); end
        end
        imem_ack_i = 1'b1; imem_data_i = 32'h3333_4444; #1;
        total++; if (pc_enable_o !== 1'b1) begin bad++; $display("FAIL dly_pcen_ack got=%b exp=1", pc_enable_o); end
`ifdef IF_STALL_CNT_EN
        total++; if (stall_cnt_o - s0 !== 16'd3) begin bad++; $display("FAIL dly_stall_cnt got=%0d exp=3", stall_cnt_o - s0); end
`else
        total++; if (stall_cnt_o !== 16'd0 || s0 !== 16'd0) begin bad++; $display("FAIL dly_stall_off got=%0d exp=0", stall_cnt_o); end
`endif
        tick();
        imem_ack_i = 1'b0; pc_i = 32'hC;
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'hC) begin bad++; $display("FAIL dly_out got=%b/%h exp=1/c", ifid_valid_o, ifid_pc4_o); end
        total++; if (ifid_instr_o !== 32'h3333_4444) begin bad++; $display("FAIL dly_instr got=%h exp=33334444", ifid_instr_o); end
    endtask

    task automatic test_hazard();
        hd_i = 1'b1; #1;
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL hz_pcen1 got=%b exp=0", pc_enable_o); end
        tick();
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'hC) begin bad++; $display("FAIL hz_hold1 got=%b/%h exp=1/c", ifid_valid_o, ifid_pc4_o); end
        imem_ack_i = 1'b1; imem_data_i = 32'h5555_6666; #1;
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL hz_pcen_ack got=%b exp=0", pc_enable_o); end
        tick();
        imem_ack_i = 1'b0; #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL hz_req_hold got=%b exp=0", imem_req_o); end
        total++; if (ifid_pc4_o !== 32'hC || ifid_instr_o !== 32'h3333_4444) begin bad++; $display("FAIL hz_ifid_hold got=%h/%h exp=c/33334444", ifid_pc4_o, ifid_instr_o); end
        for (int i = 0; i < 2; i++) begin
            total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL hz_pcen_hold[%0d] got=%b exp=0", i, pc_enable_o); end
            tick();
        end
        hd_i = 1'b0; #1;
        total++; if (pc_enable_o !== 1'b1) begin bad++; $display("FAIL hz_pcen_rel got=%b exp=1", pc_enable_o); end
        tick();
        pc_i = 32'h10;
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h10) begin bad++; $display("FAIL hz_rel_out got=%b/%h exp=1/10", ifid_valid_o, ifid_pc4_o); end
        total++; if (ifid_instr_o !== 32'h5555_6666) begin bad++; $display("FAIL hz_rel_instr got=%h exp=55556666", ifid_instr_o); end
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin bad++; $display("FAIL hz_rel_req got=%b/%h exp=1/10", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_flush_drain();
        flush_i = 1'b1; #1;
        total++; if (pc_enable_o !== 1'b1) begin bad++; $display("FAIL fl_pcen got=%b exp=1", pc_enable_o); end
        tick();
        flush_i = 1'b0; pc_i = 32'h80; #1;
        total++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== NOP) begin bad++; $display("FAIL fl_squash got=%b/%h exp=0/%h", ifid_valid_o, ifid_instr_o, NOP); end
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin bad++; $display("FAIL fl_drain_req got=%b/%h exp=1/10", imem_req_o, imem_addr_o); end
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL fl_drain_pcen got=%b exp=0", pc_enable_o); end
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF; #1;
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL fl_drain_ack_pcen got=%b exp=0", pc_enable_o); end
        tick();
        imem_ack_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'h80 || imem_req_o !== 1'b1) begin bad++; $display("FAIL fl_redirect got=%h/%b exp=80/1", imem_addr_o, imem_req_o); end
        total++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== NOP) begin bad++; $display("FAIL fl_dropped got=%b/%h exp=0/%h", ifid_valid_o, ifid_instr_o, NOP); end
    endtask

    task automatic test_flush_hd_ack();
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h7777_8888;
        tick();
        imem_ack_i = 1'b0; pc_i = 32'h84; #1;
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h84) begin bad++; $display("FAIL fh_pre got=%b/%h exp=1/84", ifid_valid_o, ifid_pc4_o); end
        flush_i = 1'b1; hd_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'h9999_0000; #1;
        total++; if (pc_enable_o !== 1'b1) begin bad++; $display("FAIL fh_pcen got=%b exp=1", pc_enable_o); end
        tick();
        flush_i = 1'b0; hd_i = 1'b0; imem_ack_i = 1'b0; pc_i = 32'h200; #1;
        total++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== NOP) begin bad++; $display("FAIL fh_squash got=%b/%h exp=0/%h", ifid_valid_o, ifid_instr_o, NOP); end
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL fh_gap_req got=%b exp=0", imem_req_o); end
        tick();
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin bad++; $display("FAIL fh_target got=%b/%h exp=1/200", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_stop();
        start_i = 1'b0; #1;
        total++; if (pc_enable_o !== 1'b0) begin bad++; $display("FAIL stop_pcen got=%b exp=0", pc_enable_o); end
        tick();
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin bad++; $display("FAIL stop_drain got=%b/%h exp=1/200", imem_req_o, imem_addr_o); end
        imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        tick();
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL stop_idle got=%b exp=0", imem_req_o); end
    endtask

    task automatic test_async_reset_and_wrap();
        start_i = 1'b1; pc_i = 32'h300;
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'hABCD_0123;
        tick();
        imem_ack_i = 1'b0; #1;
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h304) begin bad++; $display("FAIL ar_pre got=%b/%h exp=1/304", ifid_valid_o, ifid_pc4_o); end
        #1 rst_i = 1'b0;
        #1;
        total++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'd0) begin bad++; $display("FAIL ar_req got=%b/%h exp=0/0", imem_req_o, imem_addr_o); end
        total++; if (ifid_valid_o !== 1'b0 || ifid_pc4_o !== 32'd0 || ifid_instr_o !== NOP) begin bad++; $display("FAIL ar_ifid got=%b/%h/%h exp=0/0/%h", ifid_valid_o, ifid_pc4_o, ifid_instr_o, NOP); end
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL ar_stall got=%0d exp=0", stall_cnt_o); end
        tick();
        rst_i = 1'b1; pc_i = 32'hFFFF_FFFC;
        tick();
        total++; if (imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr_o); end
        imem_ack_i = 1'b1; imem_data_i = 32'h0BAD_0001;
        tick();
        imem_ack_i = 1'b0; #1;
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%b/%h exp=1/0", ifid_valid_o, ifid_pc4_o); end
        total++; if (imem_addr_o !== 32'h0 || ifid_instr_o !== 32'h0BAD_0001) begin bad++; $display("FAIL wrap_next got=%h/%h exp=0/0bad0001", imem_addr_o, ifid_instr_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_ack();
        test_hazard();
        test_flush_drain();
        test_flush_hd_ack();
        test_stop();
        test_async_reset_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
